// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, 2-entry skid buffer
// and synchronous flush; the head entry drives MEM, the skid entry absorbs back-pressure.
module exe_mem_skid_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEST_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] ST_val_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] ST_val,
    output logic [DEST_W-1:0] Dest,
    output logic [1:0]        occupancy
);

    // Entry layout, MSB first: {WB_EN, MEM_R_EN, MEM_W_EN, PC, ALU_result, ST_val, Dest}
    localparam int unsigned ST_LSB   = DEST_W;
    localparam int unsigned ALU_LSB  = DEST_W + DATA_W;
    localparam int unsigned PC_LSB   = DEST_W + 2 * DATA_W;
    localparam int unsigned CTRL_LSB = DEST_W + 3 * DATA_W;
    localparam int unsigned ENTRY_W  = CTRL_LSB + 3;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ENTRY_W-1:0] r_head;
    logic [ENTRY_W-1:0] r_skid;
    logic [ENTRY_W-1:0] w_head_nxt;
    logic [ENTRY_W-1:0] w_skid_nxt;
    logic [ENTRY_W-1:0] w_in_entry;
    logic               w_push;
    logic               w_pop;

    assign w_in_entry = {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, PC_in, ALU_result_in, ST_val_in, Dest_in};
    assign w_push     = in_valid & r_in_ready;
    assign w_pop      = r_out_valid & out_ready;

    // State register; status flags are registered from the next state so no output is combinational
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head      <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != FULL);
            r_out_valid <= (w_state_nxt != EMPTY);
            r_head      <= w_head_nxt;
            r_skid      <= w_skid_nxt;
        end
    end

    // Next-state and entry steering; control bits of a vacated entry are cleared so bubbles carry no enables
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_head_nxt  = w_in_entry;
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    w_head_nxt = w_in_entry;
                end else if (w_push) begin
                    w_skid_nxt  = w_in_entry;
                    w_state_nxt = FULL;
                end else if (w_pop) begin
                    w_head_nxt  = {3'b000, r_head[CTRL_LSB-1:0]};
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_head_nxt  = r_skid;
                    w_skid_nxt  = {3'b000, r_skid[CTRL_LSB-1:0]};
                    w_state_nxt = ONE;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
            w_head_nxt  = {3'b000, r_head[CTRL_LSB-1:0]};
            w_skid_nxt  = {3'b000, r_skid[CTRL_LSB-1:0]};
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign occupancy  = r_state;
    assign WB_EN      = r_head[CTRL_LSB+2];
    assign MEM_R_EN   = r_head[CTRL_LSB+1];
    assign MEM_W_EN   = r_head[CTRL_LSB];
    assign PC         = r_head[PC_LSB +: DATA_W];
    assign ALU_result = r_head[ALU_LSB +: DATA_W];
    assign ST_val     = r_head[ST_LSB +: DATA_W];
    assign Dest       = r_head[0 +: DEST_W];

endmodule
